// File: rtl/antirrebote_sync_pkg.sv
// Shared constants for the button/switch conditioning path.
//   - DB_ST_*            : 2-bit encodings of the debounce FSM states
//   - state_t            : enum built on those encodings
//   - DB_STABLE_CYCLES_* : stability window for simulation and board builds
//   - DB_STABLE_CYCLES_DEF : window picked by DB_BOARD_BUILD
package antirrebote_sync_pkg;

  localparam logic [1:0] DB_ST_STABLE_LO = 2'b00;
  localparam logic [1:0] DB_ST_WAIT_HI   = 2'b01;
  localparam logic [1:0] DB_ST_STABLE_HI = 2'b10;
  localparam logic [1:0] DB_ST_WAIT_LO   = 2'b11;

  typedef enum logic [1:0] {
    STABLE_LO = DB_ST_STABLE_LO,
    WAIT_HI   = DB_ST_WAIT_HI,
    STABLE_HI = DB_ST_STABLE_HI,
    WAIT_LO   = DB_ST_WAIT_LO
  } state_t;

  // Short window keeps simulations fast; the board needs ~1 ms at 50 MHz.
  localparam int unsigned DB_STABLE_CYCLES_SIM   = 4;
  localparam int unsigned DB_STABLE_CYCLES_BOARD = 50000;
  localparam bit          DB_BOARD_BUILD         = 1'b0;
  localparam int unsigned DB_STABLE_CYCLES_DEF   =
    DB_BOARD_BUILD ? DB_STABLE_CYCLES_BOARD : DB_STABLE_CYCLES_SIM;

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, loads INIT into both flops
//   d     : asynchronous input
//   q     : synchronised output (two clk edges of latency)
module sincronizador_2ff #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= INIT;
      q    <= INIT;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/antirrebote_sync.sv
// Debouncer for a raw push-button / switch line.
// The line is synchronised with two flops, and a new level is only accepted
// after the synchronised sample has differed from the current debounced
// level long enough for the stability counter to reach STABLE_CYCLES-1.
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   btn_in  : raw asynchronous input, may bounce or glitch
//   btn_db  : debounced level (registered)
//   db_rise : one-cycle strobe, first cycle of btn_db = 1
//   db_fall : one-cycle strobe, first cycle of btn_db = 0
// Parameters:
//   STABLE_CYCLES : >= 1
//   CNT_W         : must hold STABLE_CYCLES-1
//   INIT_LEVEL    : level loaded by reset (1 for active-low buttons)
module antirrebote_sync
  import antirrebote_sync_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DB_STABLE_CYCLES_DEF,
  parameter int unsigned CNT_W         = 16,
  parameter logic        INIT_LEVEL    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_db,
  output logic db_rise,
  output logic db_fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam state_t           ST_INIT  = INIT_LEVEL ? STABLE_HI : STABLE_LO;

  logic             sync2;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             db_n, rise_n, fall_n;

  sincronizador_2ff #(.INIT(INIT_LEVEL)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_in),
    .q     (sync2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      cnt     <= '0;
      btn_db  <= INIT_LEVEL;
      db_rise <= 1'b0;
      db_fall <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      btn_db  <= db_n;
      db_rise <= rise_n;
      db_fall <= fall_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    case (state)
      STABLE_LO: begin
        if (sync2) begin
          state_n = WAIT_HI;
          cnt_n   = '0;
        end
      end
      WAIT_HI: begin
        if (!sync2) begin
          // bounce: drop back without touching the output
          state_n = STABLE_LO;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = STABLE_HI;
          cnt_n   = '0;
          rise_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!sync2) begin
          state_n = WAIT_LO;
          cnt_n   = '0;
        end
      end
      WAIT_LO: begin
        if (sync2) begin
          state_n = STABLE_HI;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = STABLE_LO;
          cnt_n   = '0;
          fall_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = ST_INIT;
        cnt_n   = '0;
      end
    endcase
    // Output level follows the committed half of the state space, so it
    // holds its old value for the whole WAIT period.
    db_n = (state_n == STABLE_HI) || (state_n == WAIT_LO);
  end

endmodule
